alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Multi-cycle, width-parametrised ALU for the CDEC datapath. It is the successor to the fixed 8-bit combinational ALU.
- Keeps the same 16 base operations and SZCy flag semantics, generalised to WIDTH.
- Adds an unsigned shift-add multiply, N-bit shifts and a registered valid/ready handshake on both sides.
- Sits between the register file/operand muxes and the writeback/flag register stage.

Parameters:
WIDTH, 8, operand/result width in bits; power of two, >= 4.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  operation request
in_ready  out  1  block can accept a request (high only in IDLE)
aluop  in  5  operation code, captured on accept
a  in  WIDTH  operand A, captured on accept
b  in  WIDTH  operand B, captured on accept
cy_in  in  1  carry/borrow in, captured on accept
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  WIDTH  result (low half for MUL)
result_hi  out  WIDTH  high half of MUL product; 0 for all other ops
szcy  out  3  {S, Z, Cy} for result
busy  out  1  high in BUSY or DONE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- States: IDLE, BUSY, DONE.
  - Accept = in_valid && in_ready.
  - a, b, aluop and cy_in are registered on accept; later input changes are ignored.
- Base ops 0x00-0x0F:
  - Order: A, B, ~A, ~B, AND, OR, XOR, ZERO, A+1, A-1, A+B, A-B, A+B+cy, A-B-cy, SHL1, SHR1.
  - Computed at WIDTH+1 bits; Cy = bit WIDTH.
  - For subtracts, Cy = borrow.
  - SHL1: Cy = a[W-1]. SHR1: logical, Cy = 0.
  - Latency: IDLE -> DONE, out_valid high the cycle after accept.
- 0x10 MUL (unsigned shift-add, one bit per cycle):
  - BUSY for WIDTH cycles, then DONE; out_valid WIDTH+1 cycles after accept.
  - {result_hi, result} = a*b.
  - Cy = |result_hi.
- 0x11 SHLN / 0x12 SHRN (logical) / 0x13 SAR (arithmetic):
  - Amount n = b[$clog2(WIDTH)-1:0]; one bit per cycle.
  - BUSY for n cycles; latency n+1.
  - Cy = last bit shifted out.
  - n = 0: result = a, Cy = 0, latency 1.
- 0x14-0x1F (undefined): behave as ZERO, i.e. result 0, szcy = 3'b010, latency 1.
- Flags for every op: S = result[W-1]; Z = (result == 0). Z and S ignore result_hi.
- DONE:
  - out_valid = 1; result, result_hi and szcy held stable until out_ready.
  - On out_valid && out_ready: -> IDLE; in_ready rises next cycle.
  - No accept in the same cycle as output handshake.
  - in_valid while not in IDLE is ignored; no queuing.
- Reset, including mid-operation:
  - Next edge: state IDLE; out_valid, busy, result, result_hi and szcy all 0; in_ready 1.
  - An in-flight operation is discarded without output.
- Outputs are registered; no combinational path from inputs to result/szcy.

Decomposition:
- Package alu_mc_pkg:
  - typedef enum logic [4:0] aluop_t with all 20 named codes.
  - typedef enum state_t {IDLE, BUSY, DONE}.
  - Flag index constants FLAG_S=2, FLAG_Z=1, FLAG_CY=0.
- Sub-module alu_comb (parameter WIDTH): purely combinational base ops 0x00-0x0F.
  - Returns a WIDTH+1 result.
  - Instantiated once by alu_mc.
- Multiply/shift sequencing, counter and handshake logic live in alu_mc.

Test Plan:
1. WIDTH=8, ADD a=0xF0 b=0x20, out_ready=1 -> out_valid 1 cycle after accept, result=0x10, szcy=3'b001.
2. SUB a=0x00 b=0x01 -> result=0xFF, szcy=3'b101. Then SBC a=0x05 b=0x02 cy_in=1 -> result=0x02, szcy=3'b000.
3. MUL a=0xFF b=0xFF -> out_valid exactly 9 cycles after accept, result=0x01, result_hi=0xFE, szcy=3'b001. Then MUL a=0x00 b=0x37 -> result=0, result_hi=0, szcy=3'b010.
4. Shifts:
   - SHLN a=0x81 b=1 -> latency 2, result=0x02, szcy=3'b001.
   - SHLN a=0x81 b=3 -> latency 4, result=0x08, szcy=3'b000.
   - SAR a=0x80 b=7 -> result=0xFF, szcy=3'b100.
   - SHRN b=0 -> result=a, latency 1.
5. Backpressure: ADD result ready, out_ready held 0 for 5 cycles, with in_valid pulsed meanwhile -> out_valid stays 1, result/szcy stable, in_ready=0, pulsed request not executed. out_ready=1 -> in_ready=1 next cycle.
6. Reset asserted 3 cycles into a MUL -> next cycle out_valid=0, busy=0, in_ready=1, result=0. A following ADD a=1 b=1 returns 0x02 with szcy=3'b000.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared types and constants for the multi-cycle ALU.
//   aluop_t  - 5-bit operation codes (0x00-0x0F base ops, 0x10-0x13 sequenced ops)
//   state_t  - control FSM states
//   FLAG_*   - bit positions inside the {S, Z, Cy} flag vector
package alu_mc_pkg;

    typedef enum logic [4:0] {
        OP_A    = 5'h00,
        OP_B    = 5'h01,
        OP_NOTA = 5'h02,
        OP_NOTB = 5'h03,
        OP_AND  = 5'h04,
        OP_OR   = 5'h05,
        OP_XOR  = 5'h06,
        OP_ZERO = 5'h07,
        OP_INC  = 5'h08,
        OP_DEC  = 5'h09,
        OP_ADD  = 5'h0A,
        OP_SUB  = 5'h0B,
        OP_ADC  = 5'h0C,
        OP_SBC  = 5'h0D,
        OP_SHL1 = 5'h0E,
        OP_SHR1 = 5'h0F,
        OP_MUL  = 5'h10,
        OP_SHLN = 5'h11,
        OP_SHRN = 5'h12,
        OP_SAR  = 5'h13
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_S  = 2;
    localparam int FLAG_Z  = 1;
    localparam int FLAG_CY = 0;

endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational base operations 0x00-0x0F.
//   aluop [3:0]   - low nibble of the operation code
//   a, b [W-1:0]  - operands
//   cy_in         - carry/borrow in for ADC/SBC
//   res [W:0]     - result extended to WIDTH+1 bits; bit WIDTH is carry/borrow
module alu_comb
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cy_in,
    output logic [WIDTH:0]   res
);

    logic [WIDTH:0] ea, eb, one, cin;

    // Zero-extending to WIDTH+1 makes bit WIDTH the carry for adds and the
    // borrow for subtracts (two's-complement wrap sets it).
    assign ea  = {1'b0, a};
    assign eb  = {1'b0, b};
    assign one = {{WIDTH{1'b0}}, 1'b1};
    assign cin = {{WIDTH{1'b0}}, cy_in};

    always_comb begin
        res = '0;
        case ({1'b0, aluop})
            OP_A:    res = ea;
            OP_B:    res = eb;
            OP_NOTA: res = {1'b0, ~a};
            OP_NOTB: res = {1'b0, ~b};
            OP_AND:  res = ea & eb;
            OP_OR:   res = ea | eb;
            OP_XOR:  res = ea ^ eb;
            OP_ZERO: res = '0;
            OP_INC:  res = ea + one;
            OP_DEC:  res = ea - one;
            OP_ADD:  res = ea + eb;
            OP_SUB:  res = ea - eb;
            OP_ADC:  res = ea + eb + cin;
            OP_SBC:  res = ea - eb - cin;
            OP_SHL1: res = {a, 1'b0};
            OP_SHR1: res = {2'b00, a[WIDTH-1:1]};
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle width-parametrised ALU with valid/ready on both sides.
//   clk, reset            - clock, synchronous active-high reset
//   in_valid / in_ready   - request handshake (in_ready only in IDLE)
//   aluop, a, b, cy_in    - request fields, captured on accept
//   out_valid / out_ready - result handshake (out_valid only in DONE)
//   result, result_hi     - result (result_hi = MUL high half, else 0)
//   szcy                  - {S, Z, Cy} flags for result
//   busy                  - high in BUSY or DONE
// Base ops finish on the accept edge; MUL and N-bit shifts iterate one bit
// per cycle in BUSY before landing in DONE.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cy_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [2:0]       szcy,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);

    state_t           state;
    logic [4:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] work_hi, work_lo;
    logic [SW:0]      cnt;

    logic [WIDTH:0]   base_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic             step_out;
    logic [SW-1:0]    shamt;

    assign shamt = b[SW-1:0];

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .aluop (aluop[3:0]),
        .a     (a),
        .b     (b),
        .cy_in (cy_in),
        .res   (base_res)
    );

    function automatic logic [2:0] flags(input logic [WIDTH-1:0] r, input logic c);
        logic [2:0] f;
        f          = '0;
        f[FLAG_S]  = r[WIDTH-1];
        f[FLAG_Z]  = (r == '0);
        f[FLAG_CY] = c;
        return f;
    endfunction

    // One iteration of the sequenced op. For MUL, {work_hi, work_lo} is the
    // partial product with the multiplier consumed from work_lo's LSB; for
    // shifts work_lo holds the value being shifted and step_out the bit lost.
    always_comb begin
        mul_sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opa} : '0);
        step_hi  = work_hi;
        step_lo  = work_lo;
        step_out = 1'b0;
        case (op)
            OP_MUL: begin
                step_hi = mul_sum[WIDTH:1];
                step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
            end
            OP_SHLN: begin
                step_lo  = {work_lo[WIDTH-2:0], 1'b0};
                step_out = work_lo[WIDTH-1];
            end
            OP_SHRN: begin
                step_lo  = {1'b0, work_lo[WIDTH-1:1]};
                step_out = work_lo[0];
            end
            OP_SAR: begin
                step_lo  = {work_lo[WIDTH-1], work_lo[WIDTH-1:1]};
                step_out = work_lo[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op        <= '0;
            opa       <= '0;
            work_hi   <= '0;
            work_lo   <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            szcy      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op        <= aluop;
                        opa       <= a;
                        work_hi   <= '0;
                        work_lo   <= (aluop == OP_MUL) ? b : a;
                        result_hi <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        if (aluop == OP_MUL) begin
                            cnt   <= (SW + 1)'(WIDTH);
                            state <= BUSY;
                        end else if (aluop inside {OP_SHLN, OP_SHRN, OP_SAR}) begin
                            if (shamt == '0) begin
                                result    <= a;
                                szcy      <= flags(a, 1'b0);
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end else begin
                                cnt   <= {1'b0, shamt};
                                state <= BUSY;
                            end
                        end else begin
                            // Undefined codes 0x14-0x1F behave as ZERO.
                            result    <= aluop[4] ? '0 : base_res[WIDTH-1:0];
                            szcy      <= aluop[4] ? flags('0, 1'b0)
                                                  : flags(base_res[WIDTH-1:0], base_res[WIDTH]);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                BUSY: begin
                    work_hi <= step_hi;
                    work_lo <= step_lo;
                    cnt     <= cnt - 1'b1;
                    // Last iteration: publish the stepped value directly.
                    if (cnt == 1) begin
                        result    <= step_lo;
                        result_hi <= (op == OP_MUL) ? step_hi : '0;
                        szcy      <= flags(step_lo, (op == OP_MUL) ? |step_hi : step_out);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized and directed checks of alu_mc (WIDTH=8) against an
// arithmetic reference model.
module tb_alu_mc;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] aluop = '0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cy_in = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic [2:0] szcy;
    logic       busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .a         (a),
        .b         (b),
        .cy_in     (cy_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .szcy      (szcy),
        .busy      (busy)
    );

    // Reference model from the operation definitions, using plain integers.
    function automatic void model(input int op, input int ua, input int ub, input int c,
                                  output logic [7:0] r, output logic [7:0] rh,
                                  output logic [2:0] f, output int lat);
        int x;
        int n;
        int sa;
        int cy;
        x = 0; cy = 0; lat = 1; rh = 0;
        n = ub % 8;
        sa = (ua >= 128) ? ua - 256 : ua;
        case (op)
            0:  x = ua;
            1:  x = ub;
            2:  x = 255 - ua;
            3:  x = 255 - ub;
            4:  x = ua & ub;
            5:  x = ua | ub;
            6:  x = ua ^ ub;
            7:  x = 0;
            8:  begin x = ua + 1;       cy = (x > 255); end
            9:  begin x = ua - 1;       cy = (ua < 1); end
            10: begin x = ua + ub;      cy = (x > 255); end
            11: begin x = ua - ub;      cy = (ua < ub); end
            12: begin x = ua + ub + c;  cy = (x > 255); end
            13: begin x = ua - ub - c;  cy = (ua < ub + c); end
            14: begin x = ua * 2;       cy = ua / 128; end
            15: x = ua / 2;
            16: begin
                x = ua * ub;
                rh = 8'((x / 256) % 256);
                cy = (x / 256) != 0;
                lat = 9;
            end
            17: begin x = ua * (1 << n); cy = (n == 0) ? 0 : (ua >> (8 - n)) & 1; lat = n + 1; end
            18: begin x = ua >> n;       cy = (n == 0) ? 0 : (ua >> (n - 1)) & 1; lat = n + 1; end
            19: begin x = sa >>> n;      cy = (n == 0) ? 0 : (sa >>> (n - 1)) & 1; lat = n + 1; end
            default: x = 0;
        endcase
        r = 8'(x & 255);
        f = {r >= 8'd128, r == 8'd0, cy[0]};
    endfunction

    // Issue one request, measure latency (1 = out_valid right after the
    // accept edge), capture outputs, then complete the output handshake.
    task automatic run_op(input logic [4:0] op, input logic [7:0] aa, input logic [7:0] bb,
                          input logic c, output logic [7:0] r, output logic [7:0] rh,
                          output logic [2:0] f, output int lat);
        @(negedge clk);
        aluop = op; a = aa; b = bb; cy_in = c; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        aluop = 5'($urandom); a = 8'($urandom); b = 8'($urandom); cy_in = 1'($urandom);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r = result; rh = result_hi; f = szcy;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({out_valid, busy, in_ready, result, result_hi, szcy} !== {1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'b000}) begin
            fails++;
            $display("FAIL reset_state got ov=%b busy=%b ir=%b r=%h rh=%h f=%b", out_valid, busy, in_ready, result, result_hi, szcy);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [4:0] ops [9]  = '{5'h0A, 5'h0B, 5'h0D, 5'h10, 5'h10, 5'h11, 5'h11, 5'h13, 5'h12};
        logic [7:0] as  [9]  = '{8'hF0, 8'h00, 8'h05, 8'hFF, 8'h00, 8'h81, 8'h81, 8'h80, 8'h5A};
        logic [7:0] bs  [9]  = '{8'h20, 8'h01, 8'h02, 8'hFF, 8'h37, 8'h01, 8'h03, 8'h07, 8'h00};
        logic       cs  [9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] er  [9]  = '{8'h10, 8'hFF, 8'h02, 8'h01, 8'h00, 8'h02, 8'h08, 8'hFF, 8'h5A};
        logic [7:0] erh [9]  = '{8'h00, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [2:0] ef  [9]  = '{3'b001, 3'b101, 3'b000, 3'b001, 3'b010, 3'b001, 3'b000, 3'b100, 3'b000};
        int         el  [9]  = '{1, 1, 1, 9, 9, 2, 4, 8, 1};
        logic [7:0] r, rh;
        logic [2:0] f;
        int lat;
        for (int i = 0; i < 9; i++) begin
            run_op(ops[i], as[i], bs[i], cs[i], r, rh, f, lat);
            tests++;
            if ({r, rh, f} !== {er[i], erh[i], ef[i]} || lat != el[i]) begin
                fails++;
                $display("FAIL directed[%0d] op=%h got r=%h rh=%h f=%b lat=%0d exp r=%h rh=%h f=%b lat=%0d",
                         i, ops[i], r, rh, f, lat, er[i], erh[i], ef[i], el[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] r, rh, xr, xrh, ra, rb;
        logic [2:0] f, xf;
        logic [4:0] op;
        logic       c;
        int lat, xlat;
        for (int i = 0; i < 60; i++) begin
            op = 5'($urandom_range(0, 31));
            ra = 8'($urandom); rb = 8'($urandom); c = 1'($urandom);
            model(int'(op), int'(ra), int'(rb), int'(c), xr, xrh, xf, xlat);
            run_op(op, ra, rb, c, r, rh, f, lat);
            tests++;
            if ({r, rh, f} !== {xr, xrh, xf} || lat != xlat) begin
                fails++;
                $display("FAIL random op=%h a=%h b=%h c=%b got r=%h rh=%h f=%b lat=%0d exp r=%h rh=%h f=%b lat=%0d",
                         op, ra, rb, c, r, rh, f, lat, xr, xrh, xf, xlat);
            end
        end
    endtask

    task automatic test_backpressure();
        int waited = 0;
        @(negedge clk);
        aluop = 5'h0A; a = 8'h33; b = 8'h44; cy_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        while (!out_valid && waited < 20) begin @(negedge clk); waited++; end
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            aluop = 5'h10; a = 8'hFF; b = 8'hFF;
            tests++;
            if ({out_valid, in_ready, result, result_hi, szcy} !== {1'b1, 1'b0, 8'h77, 8'h00, 3'b000}) begin
                fails++;
                $display("FAIL backpressure[%0d] got ov=%b ir=%b r=%h rh=%h f=%b exp ov=1 ir=0 r=77 rh=00 f=000",
                         i, out_valid, in_ready, result, result_hi, szcy);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        tests++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            fails++;
            $display("FAIL release got ir=%b ov=%b busy=%b exp ir=1 ov=0 busy=0", in_ready, out_valid, busy);
        end
        repeat (3) @(negedge clk);
        tests++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            fails++;
            $display("FAIL ignored_request got ir=%b ov=%b busy=%b exp ir=1 ov=0 busy=0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r, rh;
        logic [2:0] f;
        int lat;
        @(negedge clk);
        aluop = 5'h10; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({out_valid, busy, in_ready, result, result_hi, szcy} !== {1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'b000}) begin
            fails++;
            $display("FAIL reset_mid got ov=%b busy=%b ir=%b r=%h rh=%h f=%b", out_valid, busy, in_ready, result, result_hi, szcy);
        end
        repeat (12) @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL discarded_mul got ov=%b exp 0", out_valid);
        end
        run_op(5'h0A, 8'h01, 8'h01, 1'b0, r, rh, f, lat);
        tests++;
        if ({r, rh, f} !== {8'h02, 8'h00, 3'b000} || lat != 1) begin
            fails++;
            $display("FAIL add_after_reset got r=%h rh=%h f=%b lat=%0d exp r=02 rh=00 f=000 lat=1", r, rh, f, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
